// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment type, blank pattern and hex decode table.
// Segment vectors are active-low and packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // All segments dark.
    localparam seg_t SEG_OFF = 7'h7F;

    // Hex digit glyphs 0..F, active-low gfedcba.
    localparam seg_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex2seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to 7-segment glyph decoder (active-low gfedcba).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// A frame-synchronous shadow register keeps each frame tear-free; a guard
// interval at the start of every digit slot prevents ghosting, and leading
// zeros / individual digits can be blanked.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 500
) (
    input  logic                CLOCK_50_i,
    input  logic                rst_i,
    input  logic [4*DIGITS-1:0] data_i,
    input  logic                load_i,
    input  logic [DIGITS-1:0]   blank_i,
    input  logic                lz_i,
    output logic [DIGITS-1:0]   an_o,
    output logic                ca_o,
    output logic                cb_o,
    output logic                cc_o,
    output logic                cd_o,
    output logic                ce_o,
    output logic                cf_o,
    output logic                cg_o,
    output logic                frame_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    logic [CW-1:0]         cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   pending_reg;
    logic [4*DIGITS-1:0]   disp_reg;
    logic                  pend_valid_reg;
    logic [DIGITS-1:0]     an_reg;
    seg_t                  seg_reg;
    logic                  frame_reg;

    logic                  tick;
    logic                  wrap;
    logic                  digit_on;
    logic [3:0]            nib;
    seg_t                  nib_seg;
    logic [DIGITS-1:0]     anode_sel;
    logic [3:0]            nib_arr [DIGITS];
    logic [DIGITS-1:0]     lz_zero;

    assign tick = (cnt_reg == CNT_LAST);
    assign wrap = tick && (idx_reg == IDX_LAST);

    // Per-digit nibble slices and "this digit and everything above it is zero"
    // flags. Digit 0 is never treated as a leading zero so a value of 0 still
    // shows a single "0".
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = disp_reg[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign lz_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lz_zero[gi] = (disp_reg[4*DIGITS-1 : 4*gi] == '0);
            end
        end
    endgenerate

    assign nib      = nib_arr[idx_reg];
    assign digit_on = !blank_i[idx_reg] && !(lz_i && lz_zero[idx_reg])
                      && (cnt_reg >= CNT_GUARD);

    hex_to_seg7 u_hex (
        .nib (nib),
        .seg (nib_seg)
    );

    // One-hot active-low anode pattern for the current digit index.
    always_comb begin
        anode_sel          = '1;
        anode_sel[idx_reg] = 1'b0;
    end

    // Slot prescaler and digit index; the index advances once per slot.
    always_ff @(posedge CLOCK_50_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + CNT_ONE;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_ONE;
            end
        end
    end

    // Shadow registers: loads park in pending and are committed at frame
    // wrap; a load landing exactly on the wrap goes straight to disp.
    always_ff @(posedge CLOCK_50_i or posedge rst_i) begin
        if (rst_i) begin
            pending_reg    <= '0;
            disp_reg       <= '0;
            pend_valid_reg <= 1'b0;
        end else begin
            if (load_i) begin
                pending_reg <= data_i;
            end
            if (wrap) begin
                pend_valid_reg <= 1'b0;
                if (load_i) begin
                    disp_reg <= data_i;
                end else if (pend_valid_reg) begin
                    disp_reg <= pending_reg;
                end
            end else if (load_i) begin
                pend_valid_reg <= 1'b1;
            end
        end
    end

    // Registered display outputs and frame-start pulse.
    always_ff @(posedge CLOCK_50_i or posedge rst_i) begin
        if (rst_i) begin
            an_reg    <= '1;
            seg_reg   <= SEG_OFF;
            frame_reg <= 1'b0;
        end else begin
            frame_reg <= wrap;
            an_reg    <= digit_on ? anode_sel : '1;
            seg_reg   <= digit_on ? nib_seg : SEG_OFF;
        end
    end

    assign an_o    = an_reg;
    assign frame_o = frame_reg;
    assign ca_o    = seg_reg[0];
    assign cb_o    = seg_reg[1];
    assign cc_o    = seg_reg[2];
    assign cd_o    = seg_reg[3];
    assign ce_o    = seg_reg[4];
    assign cf_o    = seg_reg[5];
    assign cg_o    = seg_reg[6];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=8, SCAN_DIV=4, GUARD=1).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [7:0]  blank_i = '0;
    logic        lz_i = 1'b0;
    logic [7:0]  an_o;
    logic        ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o;
    logic        frame_o;
    logic [6:0]  seg_obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected glyph per digit for the frame under test; 7F means dark.
    logic [6:0] tab [8];

    always #5 clk = ~clk;

    assign seg_obs = {cg_o, cf_o, ce_o, cd_o, cc_o, cb_o, ca_o};

    seg7_scan_driver #(
        .DIGITS   (8),
        .SCAN_DIV (4),
        .GUARD    (1)
    ) dut (
        .CLOCK_50_i (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .load_i     (load_i),
        .blank_i    (blank_i),
        .lz_i       (lz_i),
        .an_o       (an_o),
        .ca_o       (ca_o),
        .cb_o       (cb_o),
        .cc_o       (cc_o),
        .cd_o       (cd_o),
        .ce_o       (ce_o),
        .cf_o       (cf_o),
        .cg_o       (cg_o),
        .frame_o    (frame_o)
    );

    // Every-cycle invariants: at most one anode low, segments dark when no anode is on.
    always @(negedge clk) begin
        n_cmp++;
        if ($countones(~an_o) > 1) begin
            n_bad++;
            $display("FAIL onehot t=%0t: an_o=%h has %0d low bits, required at most 1",
                     $time, an_o, $countones(~an_o));
        end
        if (an_o == 8'hFF) begin
            n_cmp++;
            if (seg_obs !== 7'h7F) begin
                n_bad++;
                $display("FAIL dark_seg t=%0t: seg=%h with an_o=FF, required 7f", $time, seg_obs);
            end
        end
    end

    task automatic check_out(input string tag, input logic [7:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_frame);
        n_cmp++;
        if (an_o !== exp_an || seg_obs !== exp_seg || frame_o !== exp_frame) begin
            n_bad++;
            $display("FAIL %s: an=%h seg=%h frame=%b, required an=%h seg=%h frame=%b",
                     tag, an_o, seg_obs, frame_o, exp_an, exp_seg, exp_frame);
        end else begin
            $display("check %s: an=%h seg=%h frame=%b", tag, an_o, seg_obs, frame_o);
        end
    endtask

    task automatic load_now(input logic [31:0] val);
        @(negedge clk);
        data_i = val;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        $display("load %h", val);
    endtask

    // Advance to the next negedge at which frame_o is high (bounded).
    task automatic wait_frame();
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_o && cyc < 100);
        if (!frame_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_frame: frame_o=%b after %0d cycles, required 1 within 100", frame_o, cyc);
        end
    endtask

    // Starting at a frame_o negedge, check the 32 cycles of the frame against tab.
    // Optionally strobes a load at iteration load_s. Ends on the next frame_o negedge.
    task automatic check_frame(input string tag, input int load_s, input logic [31:0] load_val);
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_frame;
        int         d;
        int         c;
        int         bad_before;
        bad_before = n_bad;
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            d = s / 4;
            c = s % 4;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            if (c != 0 && tab[d] != 7'h7F) begin
                exp_an  = ~(8'h01 << d);
                exp_seg = tab[d];
            end
            exp_frame = (s == 31);
            n_cmp++;
            if (an_o !== exp_an || seg_obs !== exp_seg || frame_o !== exp_frame) begin
                n_bad++;
                $display("FAIL %s s=%0d: an=%h seg=%h frame=%b, required an=%h seg=%h frame=%b",
                         tag, s, an_o, seg_obs, frame_o, exp_an, exp_seg, exp_frame);
            end
            if (s == load_s) begin
                data_i = load_val;
                load_i = 1'b1;
            end
            if (s == load_s + 1) begin
                load_i = 1'b0;
            end
        end
        $display("frame %s: %0d bad cycles", tag, n_bad - bad_before);
    endtask

    task automatic test_reset();
        int cyc;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset_hold", 8'hFF, 7'h7F, 1'b0);
        rst_i = 1'b0;
        @(negedge clk);
        check_out("rel_cnt0", 8'hFF, 7'h7F, 1'b0);
        @(negedge clk);
        check_out("rel_cnt1", 8'hFE, 7'h40, 1'b0);
        // Asynchronous assertion between clock edges while digit 0 is lit.
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        check_out("async_rst", 8'hFF, 7'h7F, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_out("rerel_cnt0", 8'hFF, 7'h7F, 1'b0);
        @(negedge clk);
        check_out("rerel_cnt1", 8'hFE, 7'h40, 1'b0);
        cyc = 2;
        while (!frame_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 32) begin
            n_bad++;
            $display("FAIL first_frame: frame_o after %0d cycles, required 32", cyc);
        end else begin
            $display("check first_frame: frame_o after %0d cycles", cyc);
        end
    endtask

    task automatic test_scan();
        lz_i    = 1'b0;
        blank_i = 8'h00;
        load_now(32'h76543210);
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        wait_frame();
        check_frame("scan", -1, 32'h0);
        check_frame("scan_hold", -1, 32'h0);
    endtask

    task automatic test_tear_free();
        // Continues from the scan test: display holds 76543210, at a frame start.
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        check_frame("midload_old", 13, 32'h11111111);
        for (int k = 0; k < 8; k++) tab[k] = 7'h79;
        check_frame("midload_new", 30, 32'h22222222);
        for (int k = 0; k < 8; k++) tab[k] = 7'h24;
        check_frame("wrapload_new", -1, 32'h0);
        check_frame("wrapload_hold", -1, 32'h0);
    endtask

    task automatic test_leading_zero();
        lz_i    = 1'b1;
        blank_i = 8'h00;
        load_now(32'h00000A05);
        tab = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        wait_frame();
        check_frame("lz_a05", -1, 32'h0);
        load_now(32'h00000000);
        tab = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        wait_frame();
        check_frame("lz_zero", -1, 32'h0);
        lz_i = 1'b0;
        load_now(32'h00000A05);
        tab = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        wait_frame();
        check_frame("nolz_a05", -1, 32'h0);
    endtask

    task automatic test_blank();
        lz_i    = 1'b0;
        blank_i = 8'b1000_0001;
        load_now(32'h88888888);
        tab = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7F};
        wait_frame();
        check_frame("blank_81", -1, 32'h0);
        blank_i = 8'h00;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_leading_zero();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the register/switch datapath on the Nexys board. It takes a 32-bit value (8 hex nibbles) and time-multiplexes it onto the 8-digit common-anode 7-segment display.
- Active-low anodes an_o and active-low cathodes ca_o..cg_o.
- Per-digit blanking and leading-zero suppression.
- Anti-ghosting guard interval between digits.
- Tear-free updates: new data is applied only at frame boundaries.

Parameters:
DIGITS, 8, number of multiplexed digits; nibble k of data drives digit k, with digit 0 rightmost.
SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ GUARD+1.
GUARD, 500, cycles at the start of each slot during which all anodes are off.

Ports:
CLOCK_50_i  in  1  system clock, single clock domain.
rst_i  in  1  asynchronous, active-high reset.
data_i  in  4*DIGITS  hex value to display.
load_i  in  1  one-cycle strobe that captures data_i into the pending register.
blank_i  in  DIGITS  per-digit force-off mask (1 = digit dark); sampled live.
lz_i  in  1  leading-zero suppression enable; sampled live.
an_o  out  DIGITS  anode enables, active-low.
ca_o..cg_o  out  1 each  segment cathodes a..g, active-low.
frame_o  out  1  one-cycle pulse when a new frame starts (digit index wraps to 0).

Behaviour:
Reset:
- Reset is asynchronous and active-high; clock is CLOCK_50_i. On reset assertion, immediately:
  - an_o = all 1s; ca_o..cg_o = 1.
  - frame_o = 0.
  - prescaler cnt = 0; digit index idx = 0.
  - pending = 0; disp = 0; pend_valid = 0.
- Reset asserted mid-frame aborts the scan; after release, scanning restarts at digit 0, cnt 0.

Prescaler:
- cnt counts 0..SCAN_DIV-1 and wraps.
- tick = (cnt == SCAN_DIV-1).
- On tick: idx <= (idx == DIGITS-1) ? 0 : idx+1.
- wrap = tick && idx == DIGITS-1.

Shadowing:
- load_i=1 → pending <= data_i, pend_valid <= 1.
- On wrap with pend_valid=1 → disp <= pending, pend_valid <= 0.
- load_i coincident with wrap → disp <= data_i directly and pend_valid stays 0, so the newest value wins.
- Multiple loads within one frame → the last one wins.
- Without a load, disp holds its value indefinitely.

frame_o:
- Registered version of wrap, so it is high in the first cycle of digit 0 (cnt=0, idx=0).

Digit visibility:
- Let nib = disp[4*idx +: 4].
- Leading-zero suppression: lz_k = lz_i && k != 0 && disp[4*DIGITS-1 : 4*k] == 0. Digit 0 is never suppressed, so value 0 shows a single "0".
- on = !blank_i[idx] && !lz_idx && (cnt ≥ GUARD).

Registered outputs (one-cycle lag behind cnt/idx state):
- an_o <= on ? ~(1 << idx) : all 1s.
- {cg..ca} <= on ? seg(nib) : 7'h7F.
- Exactly zero or one anode is low in any cycle.

Hex decode, seg(nib), active-low gfedcba:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Timing:
- Frame period = DIGITS*SCAN_DIV cycles.
- Each digit is lit for SCAN_DIV-GUARD cycles.

Decomposition:
- Package seg7_pkg:
  - localparam SEG_OFF = 7'h7F.
  - 16-entry constant array SEG_LUT (values above).
  - function hex2seg(logic [3:0]) returning logic [6:0].
  - typedef seg_t = logic [6:0].
- Sub-module hex_to_seg7 (combinational, nibble in → seg_t out), wraps hex2seg. It is reused by other display blocks.
- The scan FSM, shadow registers and output registers stay in seg7_scan_driver.

Test Plan:
All scenarios use SCAN_DIV=4, GUARD=1, DIGITS=8.
1. Reset: hold rst_i high, toggling mid-scan → an_o=FF and segments=7F asynchronously. After release, the first lit slot is digit 0 (an_o=FE), starting on the second cycle of cnt.
2. Scan order: load 32'h76543210 (lz_i=0, blank_i=0) and wait one frame. Each 4-cycle slot shows 1 dark cycle, then an_o=FE with seg 40, then FD with seg 79, and so on up to 7F with seg 78. frame_o pulses every 32 cycles.
3. Tear-free update: load 32'h11111111 in the middle of digit 3 → the rest of the current frame still shows the old value. The new value appears from the frame_o cycle onward. Load coincident with wrap → the new value shows in that same frame.
4. Leading zeros: load 32'h00000A05 with lz_i=1 → digits 3..7 stay dark and digits 0..2 show 12, 40, 08. With 32'h0 only digit 0 lights (seg 40). With lz_i=0 all 8 digits light.
5. Blanking: blank_i=8'b1000_0001 with data 32'h88888888 → digits 0 and 7 are never lit (an_o never FE or 7F). The other digits show seg 00.
6. Invariant check every cycle: popcount(~an_o) ≤ 1, and segments = 7F whenever an_o = FF.
